// File: rtl/pool2_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : pool2_pkg
//  Purpose  : Definitions shared by the pool2 buffer controller. Holds the
//             streaming state enumeration and the pointer-advance helper.
//             The helper wraps at an arbitrary depth rather than at a power
//             of two.
//  Revision : 1.0  initial release
// ============================================================================
package pool2_pkg;

  // Streaming controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pool2_state_e;

  // Advance a circular pointer; depth-1 wraps to 0
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                          input logic [31:0] depth);
    logic [31:0] nxt;
    if (ptr == depth - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage : pool2_pkg
`default_nettype wire

// File: rtl/pool2_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pool2_skid_fifo
//  Purpose  : Small register FIFO that absorbs RAM read data returning from
//             the pipelined read port. Its depth need not be a power of two.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             clear           - synchronous flush
//             push, push_data - write one entry
//             pop             - remove the head entry
//             head_data       - current head (valid when occ != 0)
//             occ             - number of entries held
//  Revision : 1.0  initial release
// ============================================================================
module pool2_skid_fifo #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 128,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [OCC_W-1:0] occ
);

  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [OCC_W-1:0] c_occ_full = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] c_occ_one  = OCC_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             w_do_push, w_do_pop;

  always_comb begin
    w_do_pop  = pop && (occ_q != '0);
    // A push into a full FIFO is accepted only if the head leaves this cycle
    w_do_push = push && ((occ_q != c_occ_full) || w_do_pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (w_do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + c_ptr_one;
    end
    if (w_do_pop) begin
      rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + c_ptr_one;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   occ_d = occ_q + c_occ_one;
      2'b01:   occ_d = occ_q - c_occ_one;
      default: occ_d = occ_q;
    endcase

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; occupancy alone qualifies its contents
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule : pool2_skid_fifo
`default_nettype wire

// File: rtl/pool2_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pool2_buf_ctrl
//  Purpose  : Circular FIFO controller over an external simple-dual-port
//             RAM with a fixed read latency. Reads are credit-limited so
//             that every word fetched has room in the skid FIFO. This lets
//             the consumer stall at any time without losing data.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             in_valid/in_ready/in_data    - write stream (valid/ready)
//             out_valid/out_ready/out_data - read stream (valid/ready)
//             ram_wea/ram_addra/ram_dina   - RAM write port
//             ram_addrb/ram_doutb          - RAM read port (RD_LAT cycles)
//             clear                 - synchronous flush of all contents
//             count                 - words accepted and not yet popped
//             full, empty           - occupancy flags
//             stat_hwm, stat_ovf    - peak count / sticky overflow attempt
//                                     (only with POOL2_BUF_CTRL_STATS_EN)
//  Options  : `define POOL2_BUF_CTRL_STATS_EN to add the statistics outputs
//  Revision : 1.0  initial release
// ============================================================================
module pool2_buf_ctrl
  import pool2_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2160,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_doutb,
  input  logic              clear,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
`ifdef POOL2_BUF_CTRL_STATS_EN
  ,
  output logic [ADDR_W:0]   stat_hwm,
  output logic              stat_ovf
`endif
);

  localparam int               c_skid_depth = RD_LAT + 1;
  localparam int               c_occ_w      = $clog2(c_skid_depth + 1);
  localparam logic [ADDR_W:0]  c_count_max  = (ADDR_W + 1)'(DEPTH + RD_LAT + 1);
  localparam logic [ADDR_W:0]  c_ram_max    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  c_cnt_one    = (ADDR_W + 1)'(1);
  localparam logic [3:0]       c_credits    = 4'(c_skid_depth);
  localparam logic [1:0]       c_st_idle    = 2'(IDLE);
  localparam logic [1:0]       c_st_run     = 2'(RUN);
  localparam logic [1:0]       c_st_flush   = 2'(FLUSH);

  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [ADDR_W-1:0]  rptr_q, rptr_d;
  logic [ADDR_W:0]    ram_cnt_q, ram_cnt_d;   // words in RAM not yet read
  logic [ADDR_W:0]    count_q, count_d;       // words accepted, not popped
  logic [RD_LAT-1:0]  vld_q, vld_d;           // reads in flight
  logic [1:0]         state_q, state_d;

  logic               w_full;
  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_pop;
  logic               w_push;
  logic [c_occ_w-1:0] w_skid_occ;
  logic [DATA_W-1:0]  w_skid_head;
  logic [3:0]         w_inflight;
  logic [3:0]         w_used;
  logic [3:0]         w_credit_lim;

  // --------------------------------------------------------------------------
  // Handshakes and read-credit accounting
  // --------------------------------------------------------------------------
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + {3'b000, vld_q[i]};
    end
  end

  assign w_full    = (count_q == c_count_max) || (ram_cnt_q == c_ram_max);
  // Holding in_ready low during rst keeps a reset cycle from completing a
  // handshake that the reset would otherwise discard.
  assign in_ready  = !rst && !w_full && !clear;
  assign w_wr_en   = in_valid && in_ready;

  assign out_valid = (w_skid_occ != '0);
  assign out_data  = w_skid_head;
  assign w_pop     = out_valid && out_ready;

  // A pop in the current cycle returns its credit at once. Without this,
  // each credit is held for RD_LAT+2 cycles and the stream tops out below
  // one word per cycle.
  assign w_used       = 4'(w_skid_occ) + w_inflight;
  assign w_credit_lim = c_credits + {3'b000, w_pop};
  assign w_rd_en      = !clear && (ram_cnt_q != '0) && (w_used < w_credit_lim);

  // Data landing while flushing belongs to reads issued before the clear
  assign w_push = vld_q[RD_LAT-1] && (state_q != c_st_flush);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q;
    count_d   = count_q;
    vld_d     = '0;
    state_d   = state_q;

    if (w_wr_en) begin
      wptr_d = ADDR_W'(ptr_inc(32'(wptr_q), 32'(DEPTH)));
    end
    if (w_rd_en) begin
      rptr_d = ADDR_W'(ptr_inc(32'(rptr_q), 32'(DEPTH)));
    end

    // ram_cnt is registered, so a word written this cycle cannot be read
    // before the next cycle.
    case ({w_wr_en, w_rd_en})
      2'b10:   ram_cnt_d = ram_cnt_q + c_cnt_one;
      2'b01:   ram_cnt_d = ram_cnt_q - c_cnt_one;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    case ({w_wr_en, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase

    vld_d[0] = w_rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    state_d = (count_d != '0) ? c_st_run : c_st_idle;

    if (clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      count_d   = '0;
      vld_d     = '0;
      state_d   = c_st_flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      state_q   <= c_st_idle;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      vld_q     <= vld_d;
      state_q   <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Skid buffer for returning read data
  // --------------------------------------------------------------------------
  pool2_skid_fifo #(
    .DEPTH (c_skid_depth),
    .WIDTH (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (w_push),
    .push_data (ram_doutb),
    .pop       (w_pop),
    .head_data (w_skid_head),
    .occ       (w_skid_occ)
  );

  // --------------------------------------------------------------------------
  // RAM ports and status
  // --------------------------------------------------------------------------
  assign ram_wea   = w_wr_en;
  assign ram_addra = wptr_q;
  assign ram_dina  = in_data;
  assign ram_addrb = rptr_q;

  assign count = count_q;
  assign full  = w_full;
  assign empty = (count_q == '0);

`ifdef POOL2_BUF_CTRL_STATS_EN
  logic [ADDR_W:0] hwm_q, hwm_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    hwm_d = hwm_q;
    ovf_d = ovf_q;
    if (count_q > hwm_q) begin
      hwm_d = count_q;
    end
    if (in_valid && w_full) begin
      ovf_d = 1'b1;
    end
    if (clear) begin
      hwm_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      hwm_q <= hwm_d;
      ovf_q <= ovf_d;
    end
  end

  assign stat_hwm = hwm_q;
  assign stat_ovf = ovf_q;
`endif

endmodule : pool2_buf_ctrl
`default_nettype wire
